// File: rtl/controlador_memoria_datos_if.sv
// Request/response handshake plus data-memory port bundle for the load/store sequencer.
interface controlador_memoria_datos_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    // Environment side: control unit issuing requests and the memory returning rd.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/controlador_memoria_datos.sv
// Load/store sequencer for the multicycle core's data memory: byte-lane extraction
// with sign/zero extension on loads, read-modify-write for sub-doubleword stores.
module controlador_memoria_datos #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    controlador_memoria_datos_if.slave bus
);

    localparam int unsigned OFF_W = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;

    logic              req_we_q, req_we_d;
    logic [1:0]        req_size_q, req_size_d;
    logic              req_uns_q, req_uns_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

    logic [OFF_W-1:0]  off_c;

    // Size-dependent alignment: half needs addr[0]=0, word addr[1:0]=0, double addr[2:0]=0.
    function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] a);
        logic r;
        case (size)
            2'b01:   r = a[0];
            2'b10:   r = |a[1:0];
            2'b11:   r = |a[2:0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Little-endian lane select, then truncate to size and extend.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d,
                                                  input logic [OFF_W-1:0]  off,
                                                  input logic [1:0]        size,
                                                  input logic              uns);
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] r;
        s = d >> {off, 3'b000};
        case (size)
            2'b00:   r = uns ? DATA_W'(s[7:0])  : {{(DATA_W-8){s[7]}},   s[7:0]};
            2'b01:   r = uns ? DATA_W'(s[15:0]) : {{(DATA_W-16){s[15]}}, s[15:0]};
            2'b10:   r = uns ? DATA_W'(s[31:0]) : {{(DATA_W-32){s[31]}}, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // Replace lanes off..off+size-1 of the old doubleword with the low bytes of wdata.
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] wdata,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [1:0]        size);
        logic [DATA_W-1:0] mask;
        case (size)
            2'b00:   mask = DATA_W'(64'h0000_0000_0000_00FF);
            2'b01:   mask = DATA_W'(64'h0000_0000_0000_FFFF);
            2'b10:   mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
            default: mask = {DATA_W{1'b1}};
        endcase
        mask = mask << {off, 3'b000};
        return (old & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

    assign off_c = req_addr_q[OFF_W-1:0];

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we_d     = 1'b0;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        req_we_d     = req_we_q;
        req_size_d   = req_size_q;
        req_uns_d    = req_uns_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_we_d    = bus.req_we;
                    req_size_d  = bus.req_size;
                    req_uns_d   = bus.req_unsigned;
                    req_addr_d  = bus.req_addr;
                    req_wdata_d = bus.req_wdata;
                    if (misaligned(bus.req_size, bus.req_addr[OFF_W-1:0])) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (bus.req_we && (bus.req_size == 2'b11)) begin
                        state_d  = WR;
                        mem_we_d = 1'b1;
                        mem_a_d  = bus.req_addr >> 3;
                        mem_wd_d = bus.req_wdata;
                    end else begin
                        state_d = RD1;
                        mem_a_d = bus.req_addr >> 3;
                    end
                end
            end
            RD1: begin
                state_d = RD2;
            end
            // The end of RD2 is the capture point of mem_rd; the buffered doubleword
            // is folded straight into the registered result / write data here.
            RD2: begin
                if (req_we_q) begin
                    state_d  = WR;
                    mem_we_d = 1'b1;
                    mem_a_d  = req_addr_q >> 3;
                    mem_wd_d = merge(bus.mem_rd, req_wdata_q, off_c, req_size_q);
                end else begin
                    state_d      = RESP;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = extract(bus.mem_rd, off_c, req_size_q, req_uns_q);
                end
            end
            WR: begin
                state_d      = RESP;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        resp_valid_d = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);
    end

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            req_we_q     <= 1'b0;
            req_size_q   <= 2'b00;
            req_uns_q    <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_we_q     <= mem_we_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            req_we_q     <= req_we_d;
            req_size_q   <= req_size_d;
            req_uns_q    <= req_uns_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_controlador_memoria_datos.sv
// Randomized bench for the load/store sequencer against a byte-addressed memory model.
module tb_controlador_memoria_datos;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    controlador_memoria_datos_if bus ();

    controlador_memoria_datos dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory: synchronous write, combinational read, 32 doublewords.
    logic [63:0] mem [0:31];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[4:0]] <= bus.mem_wd;
    assign bus.mem_rd = mem[bus.mem_a[4:0]];

    // Reference: flat byte array, little-endian.
    logic [7:0] ref_mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;
    int we_total = 0;
    logic [63:0] last_wa = '0;
    logic [63:0] last_wd = '0;

    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            we_total++;
            last_wa = bus.mem_a;
            last_wd = bus.mem_wd;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_dw(input int idx);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[idx*8 + i];
        return v;
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata);
        int          n;
        int          base;
        int          exp_lat;
        int          exp_we;
        int          cyc;
        int          we0;
        logic        exp_err;
        logic [63:0] exp_rd;
        logic [63:0] a_before;

        n    = 1 << size;
        base = int'(addr[7:0]);
        exp_err = (int'(addr[2:0]) % n) != 0;
        exp_rd  = '0;
        if (exp_err) begin
            exp_lat = 1;
            exp_we  = 0;
        end else if (!we) begin
            exp_lat = 3;
            exp_we  = 0;
            for (int i = 0; i < n; i++) exp_rd |= 64'(ref_mem[base + i]) << (8*i);
            if (!uns && n < 8 && exp_rd[8*n-1]) exp_rd |= ~64'd0 << (8*n);
        end else begin
            exp_lat = (size == 2'b11) ? 2 : 4;
            exp_we  = 1;
            for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
        end

        @(negedge clk);
        check_eq("ready_idle", 64'(bus.req_ready), 64'd1);
        check_eq("resp_low_idle", 64'(bus.resp_valid), 64'd0);
        a_before         = bus.mem_a;
        we0              = we_total;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = {$urandom, $urandom};
        bus.req_wdata    = {$urandom, $urandom};

        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_eq("ready_busy", 64'(bus.req_ready), 64'd0);
            if (bus.resp_valid) break;
            if (cyc >= 12) begin
                check_eq("resp_timeout", 64'(cyc), 64'(exp_lat));
                break;
            end
        end
        check_eq("latency", 64'(cyc), 64'(exp_lat));
        check_eq("resp_err", 64'(bus.resp_err), 64'(exp_err));
        check_eq("resp_rdata", bus.resp_rdata, exp_rd);
        check_eq("we_pulses", 64'(we_total - we0), 64'(exp_we));
        if (exp_we != 0) begin
            check_eq("wr_addr", last_wa, 64'(base >> 3));
            check_eq("wr_data", last_wd, ref_dw(base >> 3));
        end
        if (exp_err) check_eq("mis_mem_a", bus.mem_a, a_before);
    endtask

    initial begin
        int we0;
        logic [1:0]  sz;
        logic [63:0] ad;

        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int we0;
        logic [1:0]  sz;
        logic [63:0] ad;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = mem[i][8*b +: 8];
        end

        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_ready", 64'(bus.req_ready), 64'd1);
        check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check_eq("rst_mem_a", bus.mem_a, 64'd0);
        check_eq("rst_mem_wd", bus.mem_wd, 64'd0);
        check_eq("rst_rdata", bus.resp_rdata, 64'd0);
        check_eq("rst_err", 64'(bus.resp_err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed sequence
        do_req(1'b1, 2'b11, 1'b0, 64'h10, 64'h0123456789ABCDEF);
        check_eq("dstore_a", last_wa, 64'd2);
        check_eq("dstore_wd", last_wd, 64'h0123456789ABCDEF);
        do_req(1'b0, 2'b00, 1'b0, 64'h10, '0);
        check_eq("lb_signed", bus.resp_rdata, 64'hFFFFFFFFFFFFFFEF);
        do_req(1'b0, 2'b00, 1'b1, 64'h10, '0);
        check_eq("lb_unsigned", bus.resp_rdata, 64'h00000000000000EF);
        do_req(1'b0, 2'b00, 1'b0, 64'h17, '0);
        check_eq("lb_top_lane", bus.resp_rdata, 64'h0000000000000001);
        do_req(1'b1, 2'b01, 1'b0, 64'h12, 64'hBEEF);
        check_eq("sh_rmw_wd", last_wd, 64'h01234567BEEFCDEF);
        do_req(1'b0, 2'b10, 1'b0, 64'h14, '0);
        check_eq("lw_after_sh", bus.resp_rdata, 64'h0000000001234567);
        do_req(1'b0, 2'b10, 1'b0, 64'h13, '0);
        check_eq("mis_err", 64'(bus.resp_err), 64'd1);

        // Reset while idle with non-zero registered memory port
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("idle_rst_mem_a", bus.mem_a, 64'd0);
        check_eq("idle_rst_mem_wd", bus.mem_wd, 64'd0);
        check_eq("idle_rst_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort a byte store during RD2
        @(negedge clk);
        we0              = we_total;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 64'h21;
        bus.req_wdata    = 64'h5A;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_mem_we", 64'(bus.mem_we), 64'd0);
        check_eq("abort_resp", 64'(bus.resp_valid), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check_eq("abort_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        check_eq("abort_we_count", 64'(we_total - we0), 64'd0);
        check_eq("abort_ready", 64'(bus.req_ready), 64'd1);
        do_req(1'b0, 2'b00, 1'b1, 64'h21, '0);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            sz = 2'($urandom);
            ad = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0) ad = ad & ~64'((1 << sz) - 1);
            do_req(1'($urandom), sz, 1'($urandom), ad, {$urandom, $urandom});
        end

        // Final sweep of every doubleword through loads
        for (int i = 0; i < 32; i++) do_req(1'b0, 2'b11, 1'b0, 64'(i * 8), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
